// File: rtl/phy_tx_striper.sv
// phy_tx_striper: PHY transmit front end. Accepts DATA_W-bit words over a
// valid/ready handshake and stripes each word across LANES serial lanes,
// MSB-first, one bit per lane per clock. Idle words (repeated IDLE_BYTE) fill
// every word slot that carries no data. After reset a SYNC_WORDS-long idle
// preamble is sent before the first data word can be accepted.
//
// Ports:
//   clk_32f    - bit clock, rising edge
//   reset      - asynchronous active-low reset
//   valid_in   - Data_in holds a valid word
//   Data_in    - word to transmit; lane i carries Data_in[(i+1)*SLICE-1 -: SLICE]
//   ready_out  - word accepted on this edge when valid_in is high
//   data_out   - one serial bit per lane
//   active_out - word currently on the lanes is data (not idle)
//   sync_done  - idle preamble complete
module phy_tx_striper #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LANES      = 2,
  parameter logic [7:0]  IDLE_BYTE  = 8'hBC,
  parameter int unsigned SYNC_WORDS = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] Data_in,
  output logic              ready_out,
  output logic [LANES-1:0]  data_out,
  output logic              active_out,
  output logic              sync_done
);

  localparam int unsigned Slice = DATA_W / LANES;
  localparam int unsigned Period = Slice;
  localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;
  localparam int unsigned SyncW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;

  localparam logic [CntW-1:0]  LastBit  = CntW'(Period - 1);
  localparam logic [SyncW-1:0] LastSync = SyncW'(SYNC_WORDS - 1);
  localparam logic [Slice-1:0] IdleWord = {(Slice / 8){IDLE_BYTE}};

  typedef enum logic [0:0] {StSync, StActive} state_e;

  state_e                       state_q, state_d;
  logic [CntW-1:0]              bit_cnt_q, bit_cnt_d;
  logic [SyncW-1:0]             sync_cnt_q, sync_cnt_d;
  logic [LANES-1:0][Slice-1:0]  sh_q, sh_d;
  logic                         active_q, active_d;
  logic                         sync_done_q, sync_done_d;

  logic boundary;
  logic last_sync;
  logic accept;

  always_comb begin
    boundary  = (bit_cnt_q == LastBit);
    last_sync = (sync_cnt_q == LastSync);
    // The last preamble boundary already accepts data, so exactly SYNC_WORDS
    // idle words precede the first possible data word.
    ready_out = boundary && ((state_q == StActive) || last_sync);
    accept    = valid_in && ready_out;

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q + CntW'(1);
    sync_cnt_d  = sync_cnt_q;
    active_d    = active_q;
    sync_done_d = sync_done_q;
    for (int i = 0; i < int'(LANES); i++) begin
      sh_d[i] = {sh_q[i][Slice-2:0], 1'b0};
    end

    if (boundary) begin
      bit_cnt_d = '0;
      active_d  = accept;
      for (int i = 0; i < int'(LANES); i++) begin
        sh_d[i] = accept ? Data_in[i*Slice +: Slice] : IdleWord;
      end
      case (state_q)
        StSync: begin
          if (last_sync) begin
            state_d     = StActive;
            sync_done_d = 1'b1;
          end else begin
            sync_cnt_d = sync_cnt_q + SyncW'(1);
          end
        end
        StActive: ;  // sync_cnt saturates here
        default: state_d = StSync;
      endcase
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q     <= StSync;
      bit_cnt_q   <= '0;
      sync_cnt_q  <= '0;
      sh_q        <= {LANES{IdleWord}};
      active_q    <= 1'b0;
      sync_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sync_cnt_q  <= sync_cnt_d;
      sh_q        <= sh_d;
      active_q    <= active_d;
      sync_done_q <= sync_done_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      data_out[i] = sh_q[i][Slice-1];
    end
  end

  assign active_out = active_q;
  assign sync_done  = sync_done_q;

endmodule

// File: tb/tb_phy_tx_striper.sv
// Directed bench for phy_tx_striper: default 2-lane instance plus a 4-lane
// instance (P=8). Expected lane bits come from hand-derived word/idle tables.
module tb_phy_tx_striper;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ready;
  logic [1:0]  dout;
  logic        active;
  logic        sdone;

  logic        valid4;
  logic [31:0] data4;
  logic        ready4;
  logic [3:0]  dout4;
  logic        active4;
  logic        sdone4;

  int n_total = 0;
  int n_bad = 0;

  logic [7:0] idle = 8'hBC;

  phy_tx_striper dut (
    .clk_32f   (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .Data_in   (data_in),
    .ready_out (ready),
    .data_out  (dout),
    .active_out(active),
    .sync_done (sdone)
  );

  phy_tx_striper #(
    .DATA_W(32),
    .LANES (4)
  ) dut4 (
    .clk_32f   (clk),
    .reset     (reset),
    .valid_in  (valid4),
    .Data_in   (data4),
    .ready_out (ready4),
    .data_out  (dout4),
    .active_out(active4),
    .sync_done (sdone4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Holds reset for one edge, checks the reset values, releases between
  // edges; returns at the start of cycle 0.
  task automatic do_reset();
    reset    = 1'b0;
    valid_in = 1'b0;
    valid4   = 1'b0;
    data_in  = '0;
    data4    = '0;
    @(posedge clk);
    #1;
    check("rst2", {59'd0, dout, ready, active, sdone}, {59'd0, 2'b11, 3'b000});
    check("rst4", {57'd0, dout4, ready4, active4, sdone4}, {57'd0, 4'hF, 3'b000});
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Offers w0 (and w1 back-to-back when n==2) from cycle 0 and checks the
  // 2-lane outputs for 112 cycles.
  task automatic run_words(input string name, input logic [31:0] w0, input logic [31:0] w1,
                           input int n);
    logic [31:0] w;
    logic [1:0]  ed;
    logic        in_data;
    do_reset();
    valid_in = (n > 0);
    data_in  = w0;
    for (int k = 0; k < 112; k++) begin
      if (k == 64) begin
        if (n == 2) data_in = w1;
        else valid_in = 1'b0;
      end
      if (k == 80) valid_in = 1'b0;
      #1;
      in_data = (k >= 64) && (k < 64 + 16 * n);
      w = (k < 80) ? w0 : w1;
      for (int i = 0; i < 2; i++) begin
        ed[i] = in_data ? w[i*16 + 15 - (k % 16)] : idle[7 - (k % 8)];
      end
      check($sformatf("%s k=%0d", name, k), {59'd0, dout, ready, active, sdone},
            {59'd0, ed, (k % 16 == 15) && (k >= 63), in_data, k >= 64});
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int found;
    logic [31:0] w4;
    logic [3:0]  e4;
    logic        in4;

    reset    = 1'b0;
    valid_in = 1'b0;
    valid4   = 1'b0;
    data_in  = '0;
    data4    = '0;

    run_words("idle", 32'h0, 32'h0, 0);
    run_words("ones", 32'hFFFF_FFFF, 32'h0, 1);
    run_words("three", 32'h0000_0003, 32'h0, 1);
    run_words("b2b", 32'hAAAA_AAAA, 32'h9999_9999, 2);

    // Reset in the middle of a data word.
    do_reset();
    valid_in = 1'b1;
    data_in  = 32'hFFFF_FFFF;
    for (int k = 0; k < 70; k++) begin
      if (k == 64) valid_in = 1'b0;
      @(posedge clk);
      #1;
    end
    check("pre-rst active", {63'd0, active}, 64'd1);
    reset = 1'b0;
    #1;
    check("mid-rst", {59'd0, dout, ready, active, sdone}, {59'd0, 2'b11, 3'b000});
    @(posedge clk);
    #1;
    reset = 1'b1;
    found = -1;
    for (int k = 0; k < 80; k++) begin
      #1;
      if (ready && found < 0) found = k;
      @(posedge clk);
      #1;
    end
    check("mid-rst first ready", 64'(found), 64'd63);

    // Four lanes, P=8.
    do_reset();
    valid4 = 1'b1;
    data4  = 32'h1122_3344;
    w4     = 32'h1122_3344;
    for (int k = 0; k < 48; k++) begin
      if (k == 32) valid4 = 1'b0;
      #1;
      in4 = (k >= 32) && (k < 40);
      for (int i = 0; i < 4; i++) begin
        e4[i] = in4 ? w4[i*8 + 7 - (k % 8)] : idle[7 - (k % 8)];
      end
      check($sformatf("lanes4 k=%0d", k), {57'd0, dout4, ready4, active4, sdone4},
            {57'd0, e4, (k % 8 == 7) && (k >= 31), in4, k >= 32});
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule
